macc_seq: RTL

//  Compute sequencer for the matrix accelerator: on start, computes C = A x B for square
//  DIM x DIM signed 32-bit matrices. Issues row-major reads to the A and B matrix RAMs, runs
//  a 64-bit multiply-accumulate per C element and writes each result to the C RAM.

---
 rtl/macc_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/macc_seq.sv
// macc_seq: sequences C = A x B over the A/B/C RAM ports; DIM+RD_LAT+1 cycles per C element, no backpressure.
// Define MACC_SAT_EN to saturate c_din to signed 32 bits; otherwise c_din is the low 32 accumulator bits.
module macc_seq #(
   parameter int DIM      = 8,
   parameter int ADDR_MSB = 11,
   parameter int RD_LAT   = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic                a_re,
   output logic [ADDR_MSB:0]   a_addr,
   input  logic [31:0]         a_dout,
   output logic                b_re,
   output logic [ADDR_MSB:0]   b_addr,
   input  logic [31:0]         b_dout,
   output logic                c_we,
   output logic [ADDR_MSB:0]   c_addr,
   output logic [31:0]         c_din
);
   localparam int AW = ADDR_MSB + 1;
   localparam int CW = $clog2(DIM) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIM - 1);
   localparam logic signed [63:0] MAXV = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] MINV = 64'shFFFF_FFFF_8000_0000;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t             state_q;
   logic [CW-1:0]      i_q, j_q, k_q;
   logic [2:0]         drain_q;
   logic [RD_LAT-1:0]  tag_q;
   logic signed [63:0] acc_q, acc_d, a_ext, b_ext, prod;
   logic               busy_q, done_q, ovf_q, re_q, c_we_q;
   logic [AW-1:0]      a_addr_q, b_addr_q, c_addr_q;
   logic [31:0]        c_din_q, c_res;

   function automatic logic [AW-1:0] rc_addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return AW'(r) * AW'(DIM) + AW'(c);
   endfunction

   assign a_ext = {{32{a_dout[31]}}, a_dout};
   assign b_ext = {{32{b_dout[31]}}, b_dout};
   assign prod  = a_ext * b_ext;
   // The oldest tag marks the cycle in which the RAMs present that read's data.
   assign acc_d = tag_q[RD_LAT-1] ? acc_q + prod : acc_q;

`ifdef MACC_SAT_EN
   assign c_res = (acc_d > MAXV) ? 32'h7FFF_FFFF :
                  (acc_d < MINV) ? 32'h8000_0000 : acc_d[31:0];
`else
   assign c_res = acc_d[31:0];
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         drain_q  <= '0;
         tag_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         re_q     <= 1'b0;
         c_we_q   <= 1'b0;
         a_addr_q <= '0;
         b_addr_q <= '0;
         c_addr_q <= '0;
         c_din_q  <= '0;
      end else begin
         tag_q  <= (tag_q << 1) | RD_LAT'(re_q);
         acc_q  <= acc_d;
         done_q <= 1'b0;
         c_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q  <= S_ISSUE;
                  busy_q   <= 1'b1;
                  ovf_q    <= 1'b0;
                  i_q      <= '0;
                  j_q      <= '0;
                  k_q      <= '0;
                  acc_q    <= '0;
                  re_q     <= 1'b1;
                  a_addr_q <= '0;
                  b_addr_q <= '0;
               end
            end
            S_ISSUE: begin
               if (k_q == LAST) begin
                  state_q <= S_DRAIN;
                  re_q    <= 1'b0;
                  drain_q <= '0;
               end else begin
                  k_q      <= k_q + CW'(1);
                  a_addr_q <= rc_addr(i_q, k_q + CW'(1));
                  b_addr_q <= rc_addr(k_q + CW'(1), j_q);
               end
            end
            S_DRAIN: begin
               if (drain_q == 3'(RD_LAT - 1)) begin
                  state_q  <= S_WRITE;
                  c_we_q   <= 1'b1;
                  c_addr_q <= rc_addr(i_q, j_q);
                  c_din_q  <= c_res;
               end else begin
                  drain_q <= drain_q + 3'd1;
               end
            end
            S_WRITE: begin
               acc_q <= '0;
               ovf_q <= ovf_q | (acc_q > MAXV) | (acc_q < MINV);
               k_q   <= '0;
               if (j_q == LAST) begin
                  j_q <= '0;
                  if (i_q == LAST) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     i_q      <= i_q + CW'(1);
                     state_q  <= S_ISSUE;
                     re_q     <= 1'b1;
                     a_addr_q <= rc_addr(i_q + CW'(1), '0);
                     b_addr_q <= '0;
                  end
               end else begin
                  j_q      <= j_q + CW'(1);
                  state_q  <= S_ISSUE;
                  re_q     <= 1'b1;
                  a_addr_q <= rc_addr(i_q, '0);
                  b_addr_q <= rc_addr('0, j_q + CW'(1));
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign ovf    = ovf_q;
   assign a_re   = re_q;
   assign b_re   = re_q;
   assign a_addr = a_addr_q;
   assign b_addr = b_addr_q;
   assign c_we   = c_we_q;
   assign c_addr = c_addr_q;
   assign c_din  = c_din_q;
endmodule
